fpu_operand_unpacker: RTL and testbench

Two-stage pipelined front end of the FPU. It accepts up to three raw IEEE-754 binary32 operands (a, b, c) together with the FPU opcode. It classifies each operand and splits it into sign, unbiased exponent and mantissa, normalising denormal mantissas so the hidden bit is always at bit 23. Its outputs drive the classifier and every arithmetic unit behind it (sgn/zero/inf/sNaN/qNaN/denormal flags plus exp/man) through a valid/ready handshake.

---
 rtl/fpu_operand_unpacker.sv | 236 +++++++++++++++++++++++
 tb/tb_fpu_operand_unpacker.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_operand_unpacker.sv
// fpu_operand_unpacker: two-stage binary32 operand classifier/unpacker with valid/ready flow control.
// Rev 1.0
`default_nettype none

module fpu_operand_unpacker (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        valid_in,
  output logic        ready_out,
  input  logic [4:0]  op_in,
  input  logic [2:0]  rm_in,
  input  logic [31:0] a_in,
  input  logic [31:0] b_in,
  input  logic [31:0] c_in,
  output logic        valid_out,
  input  logic        ready_in,
  output logic [4:0]  op_out,
  output logic [2:0]  rm_out,
  output logic        sgn_a,
  output logic [9:0]  exp_a,
  output logic [23:0] man_a,
  output logic        zero_a,
  output logic        inf_a,
  output logic        sNaN_a,
  output logic        qNaN_a,
  output logic        denormal_a,
  output logic        sgn_b,
  output logic [9:0]  exp_b,
  output logic [23:0] man_b,
  output logic        zero_b,
  output logic        inf_b,
  output logic        sNaN_b,
  output logic        qNaN_b,
  output logic        denormal_b,
  output logic        sgn_c,
  output logic [9:0]  exp_c,
  output logic [23:0] man_c,
  output logic        zero_c,
  output logic        inf_c,
  output logic        sNaN_c,
  output logic        qNaN_c,
  output logic        denormal_c
);

  localparam logic [9:0] c_exp_bias     = 10'd127;
  localparam logic [9:0] c_exp_special  = 10'd128;
  localparam logic [9:0] c_exp_den_base = 10'h382;  // -126 in 10-bit two's complement

  logic        r_s1_v;
  logic        r_s2_v;
  logic        w_s1_load;
  logic        w_s2_adv;
  logic [4:0]  r1_op;
  logic [2:0]  r1_rm;
  logic [4:0]  r2_op;
  logic [2:0]  r2_rm;

  logic [2:0][31:0] w_raw;
  logic [2:0]       w_sgn;
  logic [2:0][9:0]  w_exp;
  logic [2:0][23:0] w_man;
  logic [2:0]       w_zero;
  logic [2:0]       w_inf;
  logic [2:0]       w_snan;
  logic [2:0]       w_qnan;
  logic [2:0]       w_den;

  assign w_raw     = {c_in, b_in, a_in};
  assign ready_out = !r_s1_v || !r_s2_v || ready_in;
  assign w_s1_load = valid_in && ready_out;
  assign w_s2_adv  = r_s1_v && (!r_s2_v || ready_in);
  assign valid_out = r_s2_v;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_s1_v <= 1'b0;
      r_s2_v <= 1'b0;
    end else begin
      if (w_s1_load)     r_s1_v <= 1'b1;
      else if (w_s2_adv) r_s1_v <= 1'b0;
      if (w_s2_adv)      r_s2_v <= 1'b1;
      else if (ready_in) r_s2_v <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r1_op <= '0;
      r1_rm <= '0;
      r2_op <= '0;
      r2_rm <= '0;
    end else begin
      if (w_s1_load) begin
        r1_op <= op_in;
        r1_rm <= rm_in;
      end
      if (w_s2_adv) begin
        r2_op <= r1_op;
        r2_rm <= r1_rm;
      end
    end
  end

  generate
    for (genvar i = 0; i < 3; i++) begin : g_opnd
      logic [7:0]  w_e;
      logic [22:0] w_f;
      logic [4:0]  w_lz;
      logic        w_is_den;
      logic        r1_sgn, r1_zero, r1_inf, r1_snan, r1_qnan, r1_den;
      logic [7:0]  r1_e;
      logic [22:0] r1_f;
      logic [4:0]  r1_lz;
      logic [9:0]  w_exp_n;
      logic [23:0] w_man_n;
      logic        r2_sgn, r2_zero, r2_inf, r2_snan, r2_qnan, r2_den;
      logic [9:0]  r2_exp;
      logic [23:0] r2_man;

      assign w_e      = w_raw[i][30:23];
      assign w_f      = w_raw[i][22:0];
      assign w_is_den = (w_e == 8'd0) && (w_f != 23'd0);

      // Highest set bit wins: lz counts the zeros above it in {1'b0, F}.
      always_comb begin
        w_lz = '0;
        for (int k = 0; k < 23; k++) begin
          if (w_f[k]) w_lz = 5'(23 - k);
        end
      end

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          r1_sgn  <= 1'b0;
          r1_e    <= '0;
          r1_f    <= '0;
          r1_lz   <= '0;
          r1_zero <= 1'b0;
          r1_inf  <= 1'b0;
          r1_snan <= 1'b0;
          r1_qnan <= 1'b0;
          r1_den  <= 1'b0;
        end else if (w_s1_load) begin
          r1_sgn  <= w_raw[i][31];
          r1_e    <= w_e;
          r1_f    <= w_f;
          r1_lz   <= w_is_den ? w_lz : 5'd0;
          r1_zero <= (w_e == 8'd0) && (w_f == 23'd0);
          r1_inf  <= (w_e == 8'hFF) && (w_f == 23'd0);
          r1_snan <= (w_e == 8'hFF) && (w_f != 23'd0) && !w_f[22];
          r1_qnan <= (w_e == 8'hFF) && w_f[22];
          r1_den  <= w_is_den;
        end
      end

      always_comb begin
        w_exp_n = '0;
        w_man_n = '0;
        if (r1_den) begin
          w_man_n = {1'b0, r1_f} << r1_lz;
          w_exp_n = c_exp_den_base - {5'd0, r1_lz};
        end else if (r1_zero) begin
          w_exp_n = '0;
          w_man_n = '0;
        end else if (r1_inf || r1_snan || r1_qnan) begin
          w_exp_n = c_exp_special;
          w_man_n = {1'b0, r1_f};
        end else begin
          w_exp_n = {2'b00, r1_e} - c_exp_bias;
          w_man_n = {1'b1, r1_f};
        end
      end

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          r2_sgn  <= 1'b0;
          r2_exp  <= '0;
          r2_man  <= '0;
          r2_zero <= 1'b0;
          r2_inf  <= 1'b0;
          r2_snan <= 1'b0;
          r2_qnan <= 1'b0;
          r2_den  <= 1'b0;
        end else if (w_s2_adv) begin
          r2_sgn  <= r1_sgn;
          r2_exp  <= w_exp_n;
          r2_man  <= w_man_n;
          r2_zero <= r1_zero;
          r2_inf  <= r1_inf;
          r2_snan <= r1_snan;
          r2_qnan <= r1_qnan;
          r2_den  <= r1_den;
        end
      end

      assign w_sgn[i]  = r2_sgn;
      assign w_exp[i]  = r2_exp;
      assign w_man[i]  = r2_man;
      assign w_zero[i] = r2_zero;
      assign w_inf[i]  = r2_inf;
      assign w_snan[i] = r2_snan;
      assign w_qnan[i] = r2_qnan;
      assign w_den[i]  = r2_den;
    end
  endgenerate

  assign op_out     = r2_op;
  assign rm_out     = r2_rm;
  assign sgn_a      = w_sgn[0];
  assign exp_a      = w_exp[0];
  assign man_a      = w_man[0];
  assign zero_a     = w_zero[0];
  assign inf_a      = w_inf[0];
  assign sNaN_a     = w_snan[0];
  assign qNaN_a     = w_qnan[0];
  assign denormal_a = w_den[0];
  assign sgn_b      = w_sgn[1];
  assign exp_b      = w_exp[1];
  assign man_b      = w_man[1];
  assign zero_b     = w_zero[1];
  assign inf_b      = w_inf[1];
  assign sNaN_b     = w_snan[1];
  assign qNaN_b     = w_qnan[1];
  assign denormal_b = w_den[1];
  assign sgn_c      = w_sgn[2];
  assign exp_c      = w_exp[2];
  assign man_c      = w_man[2];
  assign zero_c     = w_zero[2];
  assign inf_c      = w_inf[2];
  assign sNaN_c     = w_snan[2];
  assign qNaN_c     = w_qnan[2];
  assign denormal_c = w_den[2];

endmodule

`default_nettype wire

// File: tb/tb_fpu_operand_unpacker.sv
// tb_fpu_operand_unpacker: randomized scoreboard bench for fpu_operand_unpacker.
// Rev 1.0
`default_nettype none

module tb_fpu_operand_unpacker;

  logic        clk;
  logic        reset_n;
  logic        valid_in;
  logic        ready_out;
  logic [4:0]  op_in;
  logic [2:0]  rm_in;
  logic [31:0] a_in, b_in, c_in;
  logic        valid_out;
  logic        ready_in;
  logic [4:0]  op_out;
  logic [2:0]  rm_out;
  logic        sgn_a, zero_a, inf_a, sNaN_a, qNaN_a, denormal_a;
  logic        sgn_b, zero_b, inf_b, sNaN_b, qNaN_b, denormal_b;
  logic        sgn_c, zero_c, inf_c, sNaN_c, qNaN_c, denormal_c;
  logic [9:0]  exp_a, exp_b, exp_c;
  logic [23:0] man_a, man_b, man_c;

  int n_checks = 0;
  int n_fail   = 0;
  int n_out    = 0;
  bit stall_seen = 0;
  logic [127:0] sb[$];
  logic [127:0] obs;

  fpu_operand_unpacker dut (
    .clk(clk), .reset_n(reset_n), .valid_in(valid_in), .ready_out(ready_out),
    .op_in(op_in), .rm_in(rm_in), .a_in(a_in), .b_in(b_in), .c_in(c_in),
    .valid_out(valid_out), .ready_in(ready_in), .op_out(op_out), .rm_out(rm_out),
    .sgn_a(sgn_a), .exp_a(exp_a), .man_a(man_a), .zero_a(zero_a), .inf_a(inf_a),
    .sNaN_a(sNaN_a), .qNaN_a(qNaN_a), .denormal_a(denormal_a),
    .sgn_b(sgn_b), .exp_b(exp_b), .man_b(man_b), .zero_b(zero_b), .inf_b(inf_b),
    .sNaN_b(sNaN_b), .qNaN_b(qNaN_b), .denormal_b(denormal_b),
    .sgn_c(sgn_c), .exp_c(exp_c), .man_c(man_c), .zero_c(zero_c), .inf_c(inf_c),
    .sNaN_c(sNaN_c), .qNaN_c(qNaN_c), .denormal_c(denormal_c)
  );

  assign obs = {op_out, rm_out,
                sgn_a, exp_a, man_a, zero_a, inf_a, sNaN_a, qNaN_a, denormal_a,
                sgn_b, exp_b, man_b, zero_b, inf_b, sNaN_b, qNaN_b, denormal_b,
                sgn_c, exp_c, man_c, zero_c, inf_c, sNaN_c, qNaN_c, denormal_c};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s got=%h want=%h", tag, got, want);
    end
  endtask

  // Reference: value-level decode of one binary32 operand into {sgn, exp, man, zero, inf, snan, qnan, den}.
  function automatic logic [39:0] ref_operand(input logic [31:0] x);
    int          e;
    int          p;
    logic [23:0] m;
    logic [9:0]  e10;
    logic        z, inf, sn, qn, dn;
    logic [31:0] ev;
    ev = {24'd0, x[30:23]};
    z = 0; inf = 0; sn = 0; qn = 0; dn = 0; e = 0; m = 0;
    if (ev == 0 && x[22:0] == 0) begin
      z = 1;
    end else if (ev == 0) begin
      dn = 1;
      p = 22;
      while (x[p] == 1'b0) p--;
      e = p - 149;
      m = 24'(x[22:0]) << (23 - p);
    end else if (ev == 255) begin
      e = 128;
      m = 24'(x[22:0]);
      if (x[22:0] == 0) inf = 1;
      else if (x[22]) qn = 1;
      else sn = 1;
    end else begin
      e = int'(ev) - 127;
      m = 24'(x[22:0]) + 24'h800000;
    end
    e10 = e[9:0];
    return {x[31], e10, m, z, inf, sn, qn, dn};
  endfunction

  function automatic logic [127:0] ref_bundle(input logic [31:0] a, b, c,
                                              input logic [4:0] op, input logic [2:0] rm);
    return {op, rm, ref_operand(a), ref_operand(b), ref_operand(c)};
  endfunction

  function automatic logic [31:0] rand_operand();
    logic [22:0] f;
    logic        s;
    logic [7:0]  e;
    s = 1'($urandom);
    f = 23'($urandom) >> $urandom_range(0, 22);
    case ($urandom_range(0, 5))
      0: return {s, 31'd0};
      1: begin if (f == 0) f = 23'd1; return {s, 8'd0, f}; end
      2: return {s, 8'hFF, 23'd0};
      3: begin if (f == 0) f = 23'd5; return {s, 8'hFF, f}; end
      default: begin
        e = 8'($urandom_range(1, 254));
        return {s, e, 23'($urandom)};
      end
    endcase
  endfunction

  // Scoreboard: sb holds bundles accepted but not yet delivered, so its depth equals pipeline occupancy.
  always @(negedge clk) begin
    if (reset_n) begin
      check_eq("ready_out", ready_out, !(sb.size() == 2 && !ready_in));
      if (!ready_out) stall_seen = 1;
      if (valid_out) begin
        if (sb.size() == 0) check_eq("unexpected_out", valid_out, 0);
        else begin
          check_eq($sformatf("bundle%0d", n_out), obs, sb[0]);
          if (ready_in) begin
            void'(sb.pop_front());
            n_out++;
          end
        end
      end
      if (valid_in && ready_out) sb.push_back(ref_bundle(a_in, b_in, c_in, op_in, rm_in));
    end
  end

  task automatic send(input logic [31:0] a, b, c, input logic [4:0] op, input logic [2:0] rm);
    bit ok;
    ok = 0;
    a_in = a; b_in = b; c_in = c; op_in = op; rm_in = rm;
    valid_in = 1'b1;
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      if (ready_out) begin
        ok = 1;
        break;
      end
    end
    if (!ok) check_eq("send_timeout", ready_out, 1);
    @(posedge clk); #1;
    valid_in = 1'b0;
  endtask

  task automatic send_lat(input logic [31:0] a, b, c);
    ready_in = 1'b1;
    send(a, b, c, 5'($urandom), 3'($urandom));
    @(negedge clk); check_eq("lat_edge1", valid_out, 0);
    @(negedge clk); check_eq("lat_edge2", valid_out, 1);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain();
    ready_in = 1'b1;
    for (int k = 0; k < 200; k++) begin
      if (sb.size() == 0 && !valid_out) break;
      @(posedge clk); #1;
    end
    check_eq("drain_empty", sb.size(), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    bit done;
    reset_n = 1'b0; valid_in = 1'b0; ready_in = 1'b0;
    op_in = '0; rm_in = '0; a_in = '0; b_in = '0; c_in = '0;
    #1;
    check_eq("rst_valid_out", valid_out, 0);
    check_eq("rst_ready_out", ready_out, 1);
    check_eq("rst_outputs", obs, 0);
    idle(2);
    reset_n = 1'b1;
    #1;
    check_eq("post_rst_ready", ready_out, 1);

    // Normal / zero / inf
    send_lat(32'h3F800000, 32'h80000000, 32'h7F800000);
    check_eq("t1_exp_a", exp_a, 10'd0);
    check_eq("t1_man_a", man_a, 24'h800000);
    check_eq("t1_flags_a", {zero_a, inf_a, sNaN_a, qNaN_a, denormal_a}, 5'b0);
    check_eq("t1_b", {sgn_b, zero_b}, 2'b11);
    check_eq("t1_c", {inf_c, exp_c}, {1'b1, 10'd128});
    idle(3);

    // Denormals
    send_lat(32'h00000001, 32'h00400000, 32'h007FFFFF);
    check_eq("t2_a", {denormal_a, exp_a, man_a}, {1'b1, 10'h36B, 24'h800000});
    check_eq("t2_b", {denormal_b, exp_b, man_b}, {1'b1, 10'h381, 24'h800000});
    check_eq("t2_c", {denormal_c, exp_c, man_c}, {1'b1, 10'h381, 24'hFFFFFE});
    idle(3);

    // NaNs
    send_lat(32'h7FC00001, 32'h7F800001, 32'hFFA00000);
    check_eq("t3_a", {qNaN_a, sNaN_a, man_a}, {2'b10, 24'h400001});
    check_eq("t3_b", {qNaN_b, sNaN_b}, 2'b01);
    check_eq("t3_c", {sgn_c, sNaN_c, man_c}, {2'b11, 24'h200000});
    idle(3);

    // Stream of 8 with a downstream stall
    n0 = n_out;
    stall_seen = 0;
    fork
      begin
        for (int i = 0; i < 8; i++)
          send(rand_operand(), rand_operand(), rand_operand(), 5'($urandom), 3'($urandom));
      end
      begin
        ready_in = 1'b1;
        idle(2);
        ready_in = 1'b0;
        idle(4);
        ready_in = 1'b1;
      end
    join
    drain();
    check_eq("stream_count", n_out - n0, 8);
    check_eq("stream_stalled", stall_seen, 1);

    // Random bundles, ready_in toggling every cycle
    done = 0;
    n0 = n_out;
    fork
      begin
        for (int i = 0; i < 150; i++) begin
          if ($urandom_range(0, 4) == 0) idle(1);
          send(rand_operand(), rand_operand(), rand_operand(), 5'($urandom), 3'($urandom));
        end
        done = 1;
      end
      begin
        while (!done) begin
          @(posedge clk); #1;
          ready_in = ~ready_in;
        end
      end
    join
    drain();
    check_eq("random_count", n_out - n0, 150);

    // Reset with two bundles in flight
    ready_in = 1'b0;
    send(32'h40490FDB, 32'h00000010, 32'hC0000000, 5'd3, 3'd1);
    send(32'h3F000000, 32'h7FC00000, 32'h00000000, 5'd7, 3'd2);
    check_eq("inflight_valid", valid_out, 1);
    reset_n = 1'b0;
    sb.delete();
    #1;
    check_eq("midrst_valid_out", valid_out, 0);
    check_eq("midrst_outputs", obs, 0);
    check_eq("midrst_ready_out", ready_out, 1);
    idle(1);
    reset_n = 1'b1;
    ready_in = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_eq("post_rst_no_stale", valid_out, 0);
    end
    idle(1);
    send_lat(32'h41200000, 32'h00000003, 32'hFF800000);
    check_eq("t4_a", {exp_a, man_a}, {10'd3, 24'hA00000});
    idle(1);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
